// File: rtl/prio_pkg.sv
// Shared types and helpers for the registered priority interrupt encoder.
package prio_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Index width that never collapses to zero bits for degenerate N.
  function automatic int safe_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_irq_encoder_pick.sv
// Combinational selector: first set bit of elig scanning downward, with wrap.
module prio_pick
  import prio_pkg::*;
#(
  parameter int N  = 8,
  parameter int RR = PRIO_FIXED,
  localparam int W = safe_width(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] pick
);

  int s;
  int j;

  // Fixed priority is the same downward scan, always anchored at N-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    s     = (RR == PRIO_RR) ? int'(start) : N - 1;
    for (int k = 0; k < N; k++) begin
      j = s - k;
      if (j < 0) j = j + N;
      if (!found && elig[j]) begin
        found = 1'b1;
        pick  = W'(j);
      end
    end
  end

endmodule

// File: rtl/prio_irq_encoder.sv
// Sticky, maskable request capture with fixed or round-robin selection,
// presenting one index at a time to a consumer.
module prio_irq_encoder
  import prio_pkg::*;
#(
  parameter int N    = 8,
  parameter int EDGE = 1,
  parameter int RR   = PRIO_FIXED,
  localparam int W   = safe_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         clear,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [W:0]   pend_cnt
);

  state_t       state;
  logic [N-1:0] pending;
  logic [N-1:0] req_d;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] pend_nxt;
  logic [N-1:0] elig;
  logic [W-1:0] last;
  logic [W-1:0] start;
  logic [W-1:0] pick;
  logic         found;
  logic [W:0]   cnt;

  // Handshake: valid rises with idx and both hold until the cycle ack is seen
  // high while valid=1; that cycle completes the transfer. ack with valid=0
  // is ignored. A new capture of the same line in that cycle re-arms it.
  always_comb begin
    set_vec = (EDGE != 0) ? (req & ~req_d) : req;
    clr_vec = '0;
    if (state == PRESENT && ack) clr_vec[idx] = 1'b1;
    pend_nxt = (pending & ~clr_vec) | set_vec;
    elig     = pending & ~mask;
    start    = (last == '0) ? W'(N - 1) : last - 1'b1;
    cnt      = '0;
    for (int i = 0; i < N; i++) cnt = cnt + (W + 1)'(pending[i]);
  end

  prio_pick #(
    .N (N),
    .RR(RR)
  ) u_pick (
    .elig (elig),
    .start(start),
    .found(found),
    .pick (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      req_d    <= '0;
      state    <= IDLE;
      valid    <= 1'b0;
      idx      <= '0;
      pend_cnt <= '0;
      last     <= '0;
    end else begin
      req_d <= req;
      if (clear) begin
        pending  <= '0;
        pend_cnt <= '0;
        valid    <= 1'b0;
        state    <= IDLE;
      end else begin
        pending  <= pend_nxt;
        pend_cnt <= cnt;
        case (state)
          IDLE: begin
            if (found) begin
              idx   <= pick;
              valid <= 1'b1;
              state <= PRESENT;
            end
          end
          PRESENT: begin
            if (ack) begin
              last  <= idx;
              valid <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed bench: fixed-priority edge instance plus a round-robin level instance.
module tb_prio_irq_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, mask, req_rr, mask_rr;
  logic       clear, ack, clear_rr, ack_rr;
  logic       valid, valid_rr;
  logic [2:0] idx, idx_rr;
  logic [3:0] pend_cnt, pend_cnt_rr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_irq_encoder #(.N(8), .EDGE(1), .RR(0)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .clear(clear), .ack(ack),
    .valid(valid), .idx(idx), .pend_cnt(pend_cnt)
  );

  prio_irq_encoder #(.N(8), .EDGE(0), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req_rr), .mask(mask_rr), .clear(clear_rr), .ack(ack_rr),
    .valid(valid_rr), .idx(idx_rr), .pend_cnt(pend_cnt_rr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    ack = 1'b0; req = '0; mask = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; mask = '0; clear = 1'b0; ack = 1'b0;
    req_rr = '0; mask_rr = '0; clear_rr = 1'b0; ack_rr = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || idx !== 3'd0 || pend_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_fixed valid=%b idx=%0d pend_cnt=%0d want 0 0 0", valid, idx, pend_cnt);
    end
    checks++;
    if (valid_rr !== 1'b0 || idx_rr !== 3'd0 || pend_cnt_rr !== 4'd0) begin
      failures++;
      $display("FAIL reset_rr valid=%b idx=%0d pend_cnt=%0d want 0 0 0", valid_rr, idx_rr, pend_cnt_rr);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fixed();
    req = 8'b0010_0100;
    tick();
    req = '0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL fixed_latency1 valid=%b want 0", valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd5 || pend_cnt !== 4'd2) begin
      failures++;
      $display("FAIL fixed_first valid=%b idx=%0d pend_cnt=%0d want 1 5 2", valid, idx, pend_cnt);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL fixed_idle_gap valid=%b want 0", valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd2) begin
      failures++;
      $display("FAIL fixed_second valid=%b idx=%0d want 1 2", valid, idx);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0) begin
      failures++;
      $display("FAIL fixed_drained valid=%b pend_cnt=%0d want 0 0", valid, pend_cnt);
    end
  endtask

  task automatic test_mask();
    mask = 8'h80;
    req  = 8'h88;
    tick();
    req = '0;
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd3) begin
      failures++;
      $display("FAIL mask_low valid=%b idx=%0d want 1 3", valid, idx);
    end
    mask = '0;
    ack  = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd7) begin
      failures++;
      $display("FAIL mask_released valid=%b idx=%0d want 1 7", valid, idx);
    end
    flush();
  endtask

  task automatic test_hold();
    req = 8'h04;
    tick();
    req = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      mask = i[0] ? 8'hFF : 8'h00;
      req  = i[0] ? 8'h40 : 8'h00;
      tick();
      checks++;
      if (valid !== 1'b1 || idx !== 3'd2) begin
        failures++;
        $display("FAIL hold_%0d valid=%b idx=%0d want 1 2", i, valid, idx);
      end
    end
    req  = '0;
    mask = '0;
    ack  = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd6) begin
      failures++;
      $display("FAIL hold_higher valid=%b idx=%0d want 1 6", valid, idx);
    end
    flush();
  endtask

  task automatic test_collision();
    req = 8'h10;
    tick();
    req = '0;
    tick();
    ack = 1'b1;
    req = 8'h10;
    tick();
    ack = 1'b0;
    req = '0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL collide_gap valid=%b want 0", valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd4 || pend_cnt !== 4'd1) begin
      failures++;
      $display("FAIL collide_repeat valid=%b idx=%0d pend_cnt=%0d want 1 4 1", valid, idx, pend_cnt);
    end
    flush();
  endtask

  task automatic test_rr();
    int c;
    logic [2:0] exp_idx;
    req_rr = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      c = 0;
      while (valid_rr !== 1'b1 && c < 6) begin
        tick();
        c++;
      end
      exp_idx = 3'((15 - g) % 8);
      checks++;
      if (valid_rr !== 1'b1 || idx_rr !== exp_idx) begin
        failures++;
        $display("FAIL rr_grant_%0d valid=%b idx=%0d want 1 %0d", g, valid_rr, idx_rr, exp_idx);
      end
      ack_rr = 1'b1;
      tick();
      ack_rr = 1'b0;
    end
    req_rr   = '0;
    clear_rr = 1'b1;
    tick();
    clear_rr = 1'b0;
  endtask

  task automatic test_clear_reset();
    req = 8'h0E;
    tick();
    req = '0;
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd3 || pend_cnt !== 4'd3) begin
      failures++;
      $display("FAIL clear_setup valid=%b idx=%0d pend_cnt=%0d want 1 3 3", valid, idx, pend_cnt);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0) begin
      failures++;
      $display("FAIL clear_flush valid=%b pend_cnt=%0d want 0 0", valid, pend_cnt);
    end
    req = 8'h20;
    tick();
    req = '0;
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd5) begin
      failures++;
      $display("FAIL rst_setup valid=%b idx=%0d want 1 5", valid, idx);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || idx !== 3'd0 || pend_cnt !== 4'd0) begin
      failures++;
      $display("FAIL async_rst valid=%b idx=%0d pend_cnt=%0d want 0 0 0", valid, idx, pend_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL post_rst valid=%b want 0", valid);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_mask();
    test_hold();
    test_collision();
    test_rr();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/prio_irq_encoder.md
Name: prio_irq_encoder

Overview:
- Parametrised, registered successor to the team's 8-to-3 combinational priority encoder.
- Captures N request lines into sticky pending bits and applies a per-line mask.
- Selects one eligible line by fixed-highest-index or round-robin priority, and presents its index to a consumer through a valid/ack handshake.
- Sits between peripheral event/interrupt sources and a sequencer that services one request at a time.

Parameters:
- N, 8, number of request lines; at least 2.
- W, $clog2(N), index width; derived, not overridden.
- EDGE, 1, 1 = pending set on rising edge of req[i]; 0 = pending set while req[i] is high (level).
- RR, 0, 0 = fixed priority, highest index wins; 1 = round-robin, searching downward from last granted index minus 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request lines, synchronous to clk.
- mask  in  N  1 = line ineligible for selection; capture still occurs.
- clear  in  1  synchronous flush of all pending bits and the handshake.
- ack  in  1  consumer accepts the presented index.
- valid  out  1  idx holds an accepted-pending selection.
- idx  out  W  selected line index.
- pend_cnt  out  W+1  population count of pending bits, registered.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - pending = 0, req_d = 0, state = IDLE.
  - valid = 0, idx = 0, pend_cnt = 0.
  - last = 0, so the first RR search starts at N-1 and matches fixed priority.
- Capture:
  - EDGE=1: pending[i] set when req[i] & ~req_d[i]. A req held high across reset release counts as one edge on the first cycle.
  - EDGE=0: pending[i] set while req[i]=1.
- Eligible vector: elig = pending & ~mask.
- Selection, combinational, done by sub-module:
  - Fixed mode: highest set bit of elig.
  - RR mode: first set bit scanning downward from (last-1) mod N, wrapping N-1..0.
  - No eligible bit: found=0. Never output X; idx keeps its value.
- States:
  - IDLE: if found, register idx <= pick, valid <= 1, go PRESENT; else stay.
  - PRESENT: idx and valid held stable regardless of mask or req changes.
    - On ack: clear pending[idx], last <= idx, valid <= 0, go IDLE.
    - Without ack: stay.
- Latency, EDGE=1, idle block: req rises in cycle t, pending at t+1, valid and idx at t+2.
- Throughput: one IDLE cycle between grants; maximum one grant per 2 cycles.
- Simultaneous events:
  - ack and a new set of the same bit in the same cycle: set wins, pending stays 1.
  - ack with valid=0: ignored.
  - mask asserted on the presented line while in PRESENT: no retraction; ack still clears it.
  - clear: takes priority over capture and ack. Next cycle pending=0, valid=0, state=IDLE; last unchanged.
- rst asserted mid-PRESENT: immediate return to the reset values above; the in-flight grant is lost.
- pend_cnt: reflects the pending register of the previous cycle. Range 0..N; N needs W+1 bits.

Decomposition:
- Shared package prio_pkg holds:
  - state typedef {IDLE, PRESENT};
  - mode constants PRIO_FIXED=0, PRIO_RR=1;
  - function clog2-safe width helper.
- Sub-module prio_pick (N, RR): inputs elig[N-1:0] and start[W-1:0]; outputs found and pick[W-1:0]. Purely combinational, reusable, and checked against the legacy 8-to-3 encoder when N=8 and RR=0.

Test Plan:
- Fixed priority, N=8, EDGE=1: pulse req=8'b0010_0100 in one cycle. Required: valid with idx=5 after 2 cycles; ack gives idx=2 two cycles later; then valid=0, pend_cnt=0.
- Mask: set pending bits 7 and 3 with mask=8'h80. Required: idx=3 first; clear mask and ack; idx=7 follows.
- Round-robin, RR=1: hold req=8'hFF with EDGE=0 and ack every valid. Required: idx sequence 7,6,5,...,0,7, no index repeats within 8 grants.
- Hold and no-retraction: keep ack=0 for 10 cycles while toggling mask and req. Required: idx and valid stay constant; a new higher request is served only after ack.
- Collision: in the same cycle, ack presented idx=4 and a rising edge on req[4]. Required: pending[4] stays 1 and idx=4 is re-presented after one IDLE cycle.
- Clear and reset: assert clear while PRESENT with pend_cnt=3. Required: next cycle valid=0, pend_cnt=0. Then assert rst asynchronously mid-cycle. Required: valid=0 and idx=0 immediately, without waiting for a clock edge.
